// File: rtl/pwm_fade_controller.sv
// Fade sequencer for the 8-bit PWM datapath: ramps duty_out toward a target on period boundaries.
// Optional abort input enabled by defining PWM_FADE_ABORT_EN.
module pwm_fade_controller #(
  parameter int WIDTH  = 8,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH-1:0]  cfg_target,
  input  logic [WIDTH-1:0]  cfg_max,
  input  logic [WIDTH-1:0]  cfg_step,
  input  logic [HOLD_W-1:0] cfg_hold,
`ifdef PWM_FADE_ABORT_EN
  input  logic              abort,
`endif
  output logic [WIDTH-1:0]  duty_out,
  output logic [WIDTH-1:0]  max_out,
  output logic              period_start,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, ARMED, RAMP} state_t;

  state_t             state;
  logic [WIDTH-1:0]   cnt, max_s, tgt_s, step_s, next_duty;
  logic [HOLD_W-1:0]  hold_s, hold_cnt;
  logic [WIDTH:0]     up_sum, dn_lim;
  logic               bnd, hold_exp, abort_req;

  assign bnd      = (cnt == max_out);
  assign hold_exp = (hold_cnt >= hold_s);
  assign busy     = (state != IDLE);

`ifdef PWM_FADE_ABORT_EN
  // abort seen mid-period is remembered until the boundary that acts on it
  logic abort_pend;
  assign abort_req = abort | abort_pend;
  always_ff @(posedge clk) begin
    if (rst) abort_pend <= 1'b0;
    else     abort_pend <= busy && abort_req && !bnd;
  end
`else
  assign abort_req = 1'b0;
`endif

  // saturating step toward target, one extra bit so neither direction wraps
  always_comb begin
    up_sum = {1'b0, duty_out} + {1'b0, step_s};
    dn_lim = {1'b0, tgt_s} + {1'b0, step_s};
    if (duty_out < tgt_s)
      next_duty = (up_sum >= {1'b0, tgt_s}) ? tgt_s : up_sum[WIDTH-1:0];
    else
      next_duty = ({1'b0, duty_out} <= dn_lim) ? tgt_s : duty_out - step_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      duty_out     <= '0;
      max_out      <= '1;
      period_start <= 1'b0;
      cfg_ready    <= 1'b1;
      done         <= 1'b0;
      hold_cnt     <= '0;
      max_s        <= '0;
      tgt_s        <= '0;
      step_s       <= '0;
      hold_s       <= '0;
    end else begin
      done         <= 1'b0;
      period_start <= bnd;
      cnt          <= bnd ? '0 : cnt + WIDTH'(1);
      case (state)
        IDLE: begin
          if (cfg_valid && cfg_ready) begin
            max_s     <= cfg_max;
            tgt_s     <= (cfg_target > cfg_max) ? cfg_max : cfg_target;
            step_s    <= (cfg_step == '0) ? WIDTH'(1) : cfg_step;
            hold_s    <= cfg_hold;
            cfg_ready <= 1'b0;
            state     <= ARMED;
          end
        end
        ARMED: begin
          if (bnd) begin
            if (abort_req) begin
              cfg_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              max_out  <= max_s;
              duty_out <= (duty_out < max_s) ? duty_out : max_s;
              hold_cnt <= '0;
              state    <= RAMP;
            end
          end
        end
        RAMP: begin
          if (bnd) begin
            if (!hold_exp) begin
              if (abort_req) begin
                cfg_ready <= 1'b1;
                state     <= IDLE;
              end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
              end
            end else begin
              hold_cnt <= '0;
              // the final step beats a simultaneous abort
              if (next_duty == tgt_s) begin
                duty_out  <= next_duty;
                done      <= 1'b1;
                cfg_ready <= 1'b1;
                state     <= IDLE;
              end else if (abort_req) begin
                cfg_ready <= 1'b1;
                state     <= IDLE;
              end else begin
                duty_out <= next_duty;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Scoreboarded bench for pwm_fade_controller: model predicts timed output events per command.
module tb_pwm_fade_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_target = '0, cfg_max = '0, cfg_step = '0, cfg_hold = '0;
  logic [7:0] duty_out, max_out;
  logic       period_start, busy, done;
`ifdef PWM_FADE_ABORT_EN
  logic       abort = 1'b0;
`endif

  pwm_fade_controller #(.WIDTH(8), .HOLD_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_target(cfg_target), .cfg_max(cfg_max), .cfg_step(cfg_step), .cfg_hold(cfg_hold),
`ifdef PWM_FADE_ABORT_EN
    .abort(abort),
`endif
    .duty_out(duty_out), .max_out(max_out), .period_start(period_start),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct {int t; int d; int m; bit dn;} ev_t;
  ev_t q[$];

  int cyc = 0;
  bit rst_seen = 1'b1;
  int n_cmp = 0, n_err = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // model state: current duty/max and the last period boundary edge
  int m_duty, m_max, mb, mmax;

  // monitor: every visible output change or done pulse must match the queue head
  int   prev_d, prev_m, mon_max, mon_nb;
  bit   exp_ps;
  ev_t  me;
  always @(negedge clk) begin
    if (rst_seen) begin
      prev_d = 0; prev_m = 255; mon_max = 255; mon_nb = cyc + 256;
    end else begin
      while (q.size() > 0 && q[0].t < cyc) begin
        n_cmp++; n_err++;
        $display("FAIL missed_event cyc=%0d expected t=%0d duty=%0d max=%0d done=%0d", cyc, q[0].t, q[0].d, q[0].m, q[0].dn);
        void'(q.pop_front());
      end
      if (duty_out != prev_d || max_out != prev_m || done) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output cyc=%0d got duty=%0d max=%0d done=%0d, required no change", cyc, duty_out, max_out, done);
        end else begin
          me = q.pop_front();
          if (me.t != cyc || me.d != duty_out || me.m != max_out || me.dn != done) begin
            n_err++;
            $display("FAIL output_event got t=%0d duty=%0d max=%0d done=%0d, required t=%0d duty=%0d max=%0d done=%0d",
                     cyc, duty_out, max_out, done, me.t, me.d, me.m, me.dn);
          end
          mon_max = me.m;
        end
        prev_d = duty_out; prev_m = max_out;
      end
      exp_ps = (cyc == mon_nb);
      if (exp_ps || period_start) begin
        n_cmp++;
        if (period_start !== exp_ps) begin
          n_err++;
          $display("FAIL period_start cyc=%0d got %0b required %0b", cyc, period_start, exp_ps);
        end
      end
      if (exp_ps) mon_nb = cyc + mon_max + 1;
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    q.delete();
    n_cmp++;
    if (duty_out !== 8'd0 || max_out !== 8'd255 || cfg_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || period_start !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got duty=%0d max=%0d ready=%0b busy=%0b done=%0b ps=%0b, required 0 255 1 0 0 0",
               duty_out, max_out, cfg_ready, busy, done, period_start);
    end
    @(negedge clk);
    rst = 1'b0;
    m_duty = 0; m_max = 255; mb = cyc; mmax = 255;
  endtask

  // mode: 0 plain, 1 reset mid-ramp, 2 abort mid-ramp
  task automatic run_cmd(input int tgt, input int mx, input int stp, input int hld, input int mode);
    int A, B, D, P, te, s, d, t, tx, bab, end_t;
    bit aborted, got_done;
    ev_t ev[$];
    n_cmp++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_before_cmd got ready=%0b busy=%0b, required 1 0", cfg_ready, busy);
    end
    cfg_valid = 1'b1; cfg_target = 8'(tgt); cfg_max = 8'(mx); cfg_step = 8'(stp); cfg_hold = 8'(hld);
    A = cyc + 1;
    te = (tgt > mx) ? mx : tgt;
    s  = (stp == 0) ? 1 : stp;
    P  = mx + 1;
    while (mb + mmax + 1 <= A) mb += mmax + 1;
    B = mb + mmax + 1;
    d = (m_duty < mx) ? m_duty : mx;
    if (d != m_duty || mx != m_max) ev.push_back('{B, d, mx, 1'b0});
    t = B;
    for (int k = 0; k < 400; k++) begin
      t += (hld + 1) * P;
      if (d < te) d = (d + s >= te) ? te : d + s;
      else        d = (d <= te + s) ? te : d - s;
      ev.push_back('{t, d, mx, d == te});
      if (d == te) break;
    end
    D = t;
    aborted = 1'b0; bab = D; tx = 0;
    if (mode == 1 || mode == 2) tx = $urandom_range(D, A + 2);
    if (mode == 2) begin
      aborted = 1'b1;
      bab = (tx <= B) ? B : B + ((tx - B + P - 1) / P) * P;
    end
    got_done = 1'b0;
    foreach (ev[i]) begin
      if (!aborted || ev[i].t < bab || (ev[i].t == bab && ev[i].dn)) begin
        q.push_back(ev[i]);
        m_duty = ev[i].d; m_max = ev[i].m;
        if (ev[i].dn) got_done = 1'b1;
      end
    end
    if (got_done) begin
      mb = D; mmax = mx; end_t = D;
    end else begin
      mb = bab; mmax = (bab == B) ? mmax : mx; end_t = bab;
    end
    @(negedge clk);
    n_cmp++;
    if (cfg_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL accept_state got ready=%0b busy=%0b, required 0 1", cfg_ready, busy);
    end
    // a command offered while busy must be ignored
    cfg_target = 8'($urandom); cfg_max = 8'($urandom); cfg_step = 8'($urandom); cfg_hold = 8'($urandom);
    @(negedge clk);
    cfg_valid = 1'b0;
    if (mode == 1) begin
      while (cyc < tx - 1) @(negedge clk);
      apply_reset();
      return;
    end
`ifdef PWM_FADE_ABORT_EN
    if (mode == 2) begin
      while (cyc < tx - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
`endif
    while (cyc < end_t + 1) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL events_pending at cyc=%0d got %0d left, required 0", cyc, q.size());
      q.delete();
    end
    n_cmp++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_cmd got ready=%0b busy=%0b, required 1 0", cfg_ready, busy);
    end
  endtask

  initial begin
    int mx, stp, hld, tgt, mode;
    bit big;
    @(negedge clk);
    apply_reset();
    repeat (600) @(negedge clk);
    run_cmd(10, 15, 3, 0, 0);
    run_cmd(2, 15, 4, 1, 0);
    run_cmd(200, 100, 0, 0, 0);
    run_cmd(50, 20, 1, 0, 1);
`ifdef PWM_FADE_ABORT_EN
    run_cmd(12, 15, 3, 0, 2);
`endif
    for (int i = 0; i < 25; i++) begin
      big = ($urandom_range(3, 0) == 0);
      mx  = big ? $urandom_range(40, 16) : $urandom_range(15, 0);
      stp = big ? $urandom_range(12, 4) : $urandom_range(mx, 0);
      hld = big ? $urandom_range(1, 0) : $urandom_range(3, 0);
      tgt = ($urandom_range(2, 0) == 0) ? $urandom_range(255, 0) : $urandom_range(mx, 0);
      mode = ($urandom_range(7, 0) == 0) ? 1 : 0;
`ifdef PWM_FADE_ABORT_EN
      if (mode == 0 && $urandom_range(3, 0) == 0) mode = 2;
`endif
      run_cmd(tgt, mx, stp, hld, mode);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    repeat (50) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL final_queue got %0d left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
